debouncer_bank: RTL

DEBOUNCER_BANK -- requirements
Module: debouncer_bank

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debouncer_channel.sv | 113 +++++++++++
 rtl/debouncer_bank.sv | 36 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer bank: counter sizing helper and the
// auto-repeat state encoding.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        PERIOD = 2'd2
    } rpt_state_t;

    // Bits needed to hold maxval (at least 1).
    function automatic int clog2_max(input int maxval);
        int n;
        n = 1;
        while ((maxval >> n) != 0)
            n++;
        return n;
    endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debounced channel: 2-flop synchroniser, stability qualifier, edge pulses
// and an optional auto-repeat generator.
module debouncer_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic CLK50MHZ,
    input  logic RST,
    input  logic in,
    output logic level,
    output logic press,
    output logic release_p,
    output logic repeat_p
);

    localparam int CW = clog2_max(STABLE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          done, rise, fall;

    assign done = (sync2 != level) && (cnt == CW'(STABLE_CYCLES - 1));
    assign rise = done && !level;
    assign fall = done && level;

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            release_p <= 1'b0;
            cnt       <= '0;
        end else begin
            sync1     <= in;
            sync2     <= sync1;
            press     <= rise;
            release_p <= fall;
            // Any cycle matching the current level restarts qualification.
            if (sync2 == level)
                cnt <= '0;
            else if (done) begin
                level <= sync2;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

    if (REPEAT_EN != 0) begin : g_rpt
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = clog2_max(RMAX - 1);

        rpt_state_t    state, state_n;
        logic [RW-1:0] rcnt, rcnt_n;
        logic          rep_n;

        always_ff @(posedge CLK50MHZ or posedge RST) begin
            if (RST) begin
                state    <= IDLE;
                rcnt     <= '0;
                repeat_p <= 1'b0;
            end else begin
                state    <= state_n;
                rcnt     <= rcnt_n;
                repeat_p <= rep_n;
            end
        end

        // A falling edge (or a low level) wins over any pending repeat pulse.
        always_comb begin
            state_n = state;
            rcnt_n  = rcnt;
            rep_n   = 1'b0;
            if (fall || (!level && !rise)) begin
                state_n = IDLE;
                rcnt_n  = '0;
            end else if (rise) begin
                state_n = DELAY;
                rcnt_n  = '0;
            end else begin
                case (state)
                    DELAY: begin
                        if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                            rep_n   = 1'b1;
                            state_n = PERIOD;
                            rcnt_n  = '0;
                        end else
                            rcnt_n = rcnt + 1'b1;
                    end
                    PERIOD: begin
                        if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                            rep_n  = 1'b1;
                            rcnt_n = '0;
                        end else
                            rcnt_n = rcnt + 1'b1;
                    end
                    default: begin
                        state_n = IDLE;
                        rcnt_n  = '0;
                    end
                endcase
            end
        end
    end else begin : g_norpt
        assign repeat_p = 1'b0;
    end

endmodule

// File: rtl/debouncer_bank.sv
// Bank of independent debounced inputs. The release/repeat outputs carry a _p
// suffix because the bare words are reserved in SystemVerilog.
module debouncer_bank #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                CLK50MHZ,
    input  logic                RST,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_p,
    output logic [CHANNELS-1:0] repeat_p
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debouncer_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .CLK50MHZ (CLK50MHZ),
            .RST      (RST),
            .in       (in[i]),
            .level    (level[i]),
            .press    (press[i]),
            .release_p(release_p[i]),
            .repeat_p (repeat_p[i])
        );
    end

endmodule
